// File: rtl/rv_mem_arbiter.sv
// ============================================================================
// rv_mem_arbiter : shares one single-port memory among loader, data and fetch
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                ld_req,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_wdata,
  input  logic [DATA_W/8-1:0] ld_wstrb,
  output logic                ld_gnt,
  output logic                ld_rvalid,
  output logic [DATA_W-1:0]   ld_rdata,

  input  logic                dt_req,
  input  logic                dt_we,
  input  logic [ADDR_W-1:0]   dt_addr,
  input  logic [DATA_W-1:0]   dt_wdata,
  input  logic [DATA_W/8-1:0] dt_wstrb,
  output logic                dt_gnt,
  output logic                dt_rvalid,
  output logic [DATA_W-1:0]   dt_rdata,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                core_stall
);

  localparam int          STRB_W = DATA_W / 8;
  localparam logic [3:0]  LIM    = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_DT   = 2'd2,
    OWN_IF   = 2'd3
  } own_e;

  own_e       rd_own_q, rd_own_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  logic starved;
  logic sel_ld, sel_dt, sel_if;

  // Grant decision; every grant is masked while reset is held low.
  always_comb begin
    starved = (wait_cnt_q == LIM) && if_req;
    sel_ld  = rst_n && ld_req;
    sel_if  = rst_n && !ld_req && if_req && (starved || !dt_req);
    sel_dt  = rst_n && !ld_req && dt_req && !starved;
  end

  assign ld_gnt     = sel_ld;
  assign dt_gnt     = sel_dt;
  assign if_gnt     = sel_if;
  assign mem_en     = sel_ld | sel_dt | sel_if;
  assign core_stall = rst_n & if_req & ~sel_if;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (sel_ld) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_wstrb = ld_wstrb;
    end else if (sel_dt) begin
      mem_we    = dt_we;
      mem_addr  = dt_addr;
      mem_wdata = dt_wdata;
      mem_wstrb = dt_wstrb;
    end else if (sel_if) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    rd_own_d = OWN_NONE;
    if (sel_ld && !ld_we) begin
      rd_own_d = OWN_LD;
    end else if (sel_dt && !dt_we) begin
      rd_own_d = OWN_DT;
    end else if (sel_if) begin
      rd_own_d = OWN_IF;
    end
  end

  // Counter freezes during loader ownership so a burst does not age fetch.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!sel_ld) begin
      if (!if_req || sel_if) begin
        wait_cnt_d = 4'd0;
      end else if (sel_dt && (wait_cnt_q != LIM)) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_own_q   <= OWN_NONE;
      wait_cnt_q <= 4'd0;
    end else begin
      rd_own_q   <= rd_own_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    ld_rvalid = 1'b0;
    dt_rvalid = 1'b0;
    if_rvalid = 1'b0;
    ld_rdata  = '0;
    dt_rdata  = '0;
    if_rdata  = '0;
    if (rst_n) begin
      case (rd_own_q)
        OWN_LD: begin
          ld_rvalid = 1'b1;
          ld_rdata  = mem_rdata;
        end
        OWN_DT: begin
          dt_rvalid = 1'b1;
          dt_rdata  = mem_rdata;
        end
        OWN_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = (STRB_W == 0);

endmodule

`default_nettype wire

// File: tb/tb_rv_mem_arbiter.sv
// ============================================================================
// tb_rv_mem_arbiter : directed and randomized checks against a reference model
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_req, ld_we, dt_req, dt_we, if_req;
  logic [AW-1:0] ld_addr, dt_addr, if_addr;
  logic [DW-1:0] ld_wdata, dt_wdata, mem_rdata;
  logic [SW-1:0] ld_wstrb, dt_wstrb;
  logic          ld_gnt, dt_gnt, if_gnt;
  logic          ld_rvalid, dt_rvalid, if_rvalid;
  logic [DW-1:0] ld_rdata, dt_rdata, if_rdata;
  logic          mem_en, mem_we, core_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_wstrb(ld_wstrb), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
    .dt_wstrb(dt_wstrb), .dt_gnt(dt_gnt), .dt_rvalid(dt_rvalid), .dt_rdata(dt_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .core_stall(core_stall)
  );

  int tests = 0;
  int fails = 0;
  // Reference state: fetch loss count, owner of the read issued last cycle
  // (0 none, 1 loader, 2 data, 3 fetch) and the winner of the last cycle.
  int m_losses = 0;
  int m_owner  = 0;
  int last_win = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_wstrb = '0;
    dt_req = 0; dt_we = 0; dt_addr = '0; dt_wdata = '0; dt_wstrb = '0;
    if_req = 0; if_addr = '0;
  endtask

  // Check every output against the rules for the current inputs, then clock.
  task automatic step();
    int win;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [SW-1:0] e_wstrb;
    logic [8:0]    e_ctl, o_ctl;
    logic [DW-1:0] e_rd [1:3];
    #2;
    win = 0;
    if (rst_n) begin
      if (ld_req)                          win = 1;
      else if (if_req && m_losses >= LIM)  win = 3;
      else if (dt_req)                     win = 2;
      else if (if_req)                     win = 3;
    end
    e_we = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
    case (win)
      1: begin e_we = ld_we; e_addr = ld_addr; e_wdata = ld_wdata; e_wstrb = ld_wstrb; end
      2: begin e_we = dt_we; e_addr = dt_addr; e_wdata = dt_wdata; e_wstrb = dt_wstrb; end
      3: e_addr = if_addr;
      default: ;
    endcase
    for (int k = 1; k <= 3; k++) e_rd[k] = (rst_n && m_owner == k) ? mem_rdata : '0;
    e_ctl = {win == 1, win == 2, win == 3, win != 0, e_we,
             rst_n && if_req && win != 3,
             rst_n && m_owner == 1, rst_n && m_owner == 2, rst_n && m_owner == 3};
    o_ctl = {ld_gnt, dt_gnt, if_gnt, mem_en, mem_we, core_stall,
             ld_rvalid, dt_rvalid, if_rvalid};
    chk("ctl", 32'(o_ctl), 32'(e_ctl));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
    chk("ld_rdata", ld_rdata, e_rd[1]);
    chk("dt_rdata", dt_rdata, e_rd[2]);
    chk("if_rdata", if_rdata, e_rd[3]);
    if (!rst_n) begin
      m_losses = 0;
      m_owner  = 0;
    end else begin
      m_owner = (win == 3 || (win != 0 && !e_we)) ? win : 0;
      if (win != 1) begin
        if (!if_req || win == 3) m_losses = 0;
        else if (win == 2)       m_losses = (m_losses + 1 > LIM) ? LIM : m_losses + 1;
      end
    end
    last_win = win;
    @(posedge clk);
    #1;
  endtask

  // Requesters hold their request until granted, occasionally abandoning it.
  task automatic rand_drive();
    if (last_win == 1) ld_req = 0;
    if (last_win == 2) dt_req = 0;
    if (last_win == 3) if_req = 0;
    if (!ld_req && $urandom_range(7) == 0) begin
      ld_req = 1; ld_we = 1'($urandom); ld_addr = $urandom;
      ld_wdata = $urandom; ld_wstrb = 4'($urandom_range(15));
    end else if (ld_req && $urandom_range(15) == 0) ld_req = 0;
    if (!dt_req && $urandom_range(1) == 0) begin
      dt_req = 1; dt_we = 1'($urandom); dt_addr = $urandom;
      dt_wdata = $urandom; dt_wstrb = 4'($urandom_range(15));
    end else if (dt_req && $urandom_range(15) == 0) dt_req = 0;
    if (!if_req && $urandom_range(3) != 0) begin
      if_req = 1; if_addr = $urandom;
    end else if (if_req && $urandom_range(31) == 0) if_req = 0;
    mem_rdata = $urandom;
    rst_n = ($urandom_range(99) != 0);
  endtask

  initial begin
    logic [11:0] seq;
    rst_n = 0; mem_rdata = '0;
    clear_inputs();
    @(posedge clk); #1;
    if_req = 1;
    step();

    // single fetch read
    rst_n = 1; clear_inputs();
    if_req = 1; if_addr = 32'h10;
    step();
    if_req = 0; mem_rdata = 32'h0050_0093;
    #1 chk("fetch_rdata", if_rdata, 32'h0050_0093);
    step();

    // data write beats fetch, fetch follows
    if_req = 1; if_addr = 32'h14;
    dt_req = 1; dt_we = 1; dt_addr = 32'h200; dt_wdata = 32'hDEAD_BEEF; dt_wstrb = 4'hF;
    #1 chk("contend_stall", 32'(core_stall), 32'd1);
    step();
    dt_req = 0;
    #1 chk("contend_ifgnt", 32'(if_gnt), 32'd1);
    step();
    if_req = 0;
    step();

    // starvation: four data reads then a forced fetch
    clear_inputs();
    if_req = 1; dt_req = 1; dt_addr = 32'h300; if_addr = 32'h20;
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      #1 seq = {seq[9:0], if_gnt, dt_gnt};
      step();
    end
    chk("starve_seq", 32'(seq), 32'(12'b01_01_01_01_10_01));
    clear_inputs();
    step();

    // loader burst blocks everyone
    ld_req = 1; ld_we = 1; ld_addr = 32'h40; ld_wdata = 32'h1234_5678; ld_wstrb = 4'h3;
    dt_req = 1; if_req = 1; dt_addr = 32'h44; if_addr = 32'h48;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ld_burst", 32'({ld_gnt, core_stall}), 32'd3);
      step();
    end
    ld_req = 0;
    for (int i = 0; i < 6; i++) step();
    clear_inputs();
    step();

    // back-to-back reads to different owners
    dt_req = 1; dt_addr = 32'h80;
    step();
    dt_req = 0; if_req = 1; if_addr = 32'h84; mem_rdata = 32'hA5A5_0001;
    #1 chk("b2b_dt", 32'({dt_rvalid, if_rvalid}), 32'd2);
    step();
    if_req = 0; mem_rdata = 32'h5A5A_0002;
    #1 chk("b2b_if", if_rdata, 32'h5A5A_0002);
    step();

    // reset while a read is in flight
    dt_req = 1; dt_addr = 32'h90;
    step();
    rst_n = 0; dt_req = 0; mem_rdata = 32'hCAFE_F00D;
    step();
    rst_n = 1;
    #1 chk("rst_drop", 32'(dt_rvalid), 32'd0);
    step();

    clear_inputs();
    for (int i = 0; i < 500; i++) begin
      rand_drive();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
